// File: rtl/dcache_tag_pkg.sv
// Shared types and address-field helpers for the L1 data-cache tag controller.
package dcache_tag_pkg;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_INDEX_W  = 5;
  localparam int DEF_OFFSET_W = 4;
  localparam int DEF_TAG_W    = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MISS_WAIT,
    FILL
  } state_t;

  function automatic logic [DEF_TAG_W-1:0] addr_tag(input logic [DEF_ADDR_W-1:0] addr);
    return addr[DEF_ADDR_W-1 -: DEF_TAG_W];
  endfunction

  function automatic logic [DEF_INDEX_W-1:0] addr_idx(input logic [DEF_ADDR_W-1:0] addr);
    return addr[DEF_OFFSET_W +: DEF_INDEX_W];
  endfunction

endpackage

// File: rtl/dcache_tag_state.sv
// Per-set valid and LRU flops for the 2-way tag array; one read port shared by updates.
module dcache_tag_state
  import dcache_tag_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_clr,
  input  logic [INDEX_W-1:0] idx,
  input  logic               hit_upd,
  input  logic               hit_way,
  input  logic               fill_set,
  input  logic               fill_way,
  output logic [1:0]         valid,
  output logic               lru
);

  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0] valid_bits [2];
  logic [SETS-1:0] lru_bits;

  // lru names the way to replace next, so it always points away from the last-touched way
  always_ff @(posedge clk) begin
    if (rst || flush_clr) begin
      valid_bits[0] <= '0;
      valid_bits[1] <= '0;
      lru_bits      <= '0;
    end else begin
      if (hit_upd) begin
        lru_bits[idx] <= ~hit_way;
      end
      if (fill_set) begin
        valid_bits[fill_way][idx] <= 1'b1;
        lru_bits[idx]             <= ~fill_way;
      end
    end
  end

  assign valid = {valid_bits[1][idx], valid_bits[0][idx]};
  assign lru   = lru_bits[idx];

endmodule

// File: rtl/dcache_tag_ctrl.sv
// Tag-lookup FSM for the 2-way L1 D-cache: reads/compares tags, picks victims, writes refills.
// Optional hit/miss counters are enabled by defining DCACHE_TAG_STATS_EN.
module dcache_tag_ctrl
  import dcache_tag_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int INDEX_W  = DEF_INDEX_W,
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic               resp_way,
  input  logic               fill_done,
  input  logic               flush,
  output logic               tag_cs,
  output logic               tag_oe,
  output logic [INDEX_W-1:0] tag_a,
  output logic [TAG_W-1:0]   tag_di,
  output logic               tag_web1,
  output logic               tag_web2,
  input  logic [TAG_W-1:0]   tag_do1,
  input  logic [TAG_W-1:0]   tag_do2
`ifdef DCACHE_TAG_STATS_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`endif
);

  state_t             state;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] idx_q;
  logic               victim_q;

  logic       accept;
  logic       flush_clr;
  logic [1:0] set_valid;
  logic       set_lru;
  logic       hit0;
  logic       hit1;
  logic       hit;
  logic       hit_way;
  logic       lk_victim;
  logic       addr_offset_unused;

  assign addr_offset_unused = ^req_addr[OFFSET_W-1:0];

  assign req_ready = (state == IDLE);
  assign accept    = req_ready && req_valid && !flush;
  assign flush_clr = req_ready && flush;

  assign hit0      = set_valid[0] && (tag_do1 == tag_q);
  assign hit1      = set_valid[1] && (tag_do2 == tag_q);
  assign hit       = hit0 || hit1;
  assign hit_way   = !hit0;
  assign lk_victim = !set_valid[0] ? 1'b0 : (!set_valid[1] ? 1'b1 : set_lru);

  dcache_tag_state #(
    .INDEX_W (INDEX_W)
  ) u_state (
    .clk       (clk),
    .rst       (rst),
    .flush_clr (flush_clr),
    .idx       (idx_q),
    .hit_upd   ((state == LOOKUP) && hit),
    .hit_way   (hit_way),
    .fill_set  (state == FILL),
    .fill_way  (victim_q),
    .valid     (set_valid),
    .lru       (set_lru)
  );

  // The tag read is launched in the accept cycle so the array data lines up with LOOKUP
  always_comb begin
    tag_cs     = 1'b0;
    tag_oe     = 1'b0;
    tag_a      = '0;
    tag_di     = '0;
    tag_web1   = 1'b0;
    tag_web2   = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    resp_way   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          tag_cs = 1'b1;
          tag_oe = 1'b1;
          tag_a  = req_addr[OFFSET_W +: INDEX_W];
        end
      end
      LOOKUP: begin
        resp_valid = 1'b1;
        resp_hit   = hit;
        resp_way   = hit ? hit_way : lk_victim;
      end
      FILL: begin
        tag_cs   = 1'b1;
        tag_a    = idx_q;
        tag_di   = tag_q;
        tag_web1 = !victim_q;
        tag_web2 = victim_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:      if (accept) state <= LOOKUP;
        LOOKUP:    state <= hit ? IDLE : MISS_WAIT;
        MISS_WAIT: if (fill_done) state <= FILL;
        FILL:      state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Request fields and victim are only consumed in states reached after they are loaded
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q <= req_addr[ADDR_W-1 -: TAG_W];
      idx_q <= req_addr[OFFSET_W +: INDEX_W];
    end
    if (state == LOOKUP) begin
      victim_q <= lk_victim;
    end
  end

`ifdef DCACHE_TAG_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Self-checking bench for dcache_tag_ctrl with a behavioural 2-way cache model and tag-array model.
module tb_dcache_tag_ctrl;

  localparam int TAG_W = 23;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_addr = '0;
  logic             resp_valid;
  logic             resp_hit;
  logic             resp_way;
  logic             fill_done = 1'b0;
  logic             flush = 1'b0;
  logic             tag_cs;
  logic             tag_oe;
  logic [4:0]       tag_a;
  logic [TAG_W-1:0] tag_di;
  logic             tag_web1;
  logic             tag_web2;
  logic [TAG_W-1:0] tag_do1;
  logic [TAG_W-1:0] tag_do2;
`ifdef DCACHE_TAG_STATS_EN
  logic [31:0]      hit_cnt;
  logic [31:0]      miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_tag_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_way   (resp_way),
    .fill_done  (fill_done),
    .flush      (flush),
    .tag_cs     (tag_cs),
    .tag_oe     (tag_oe),
    .tag_a      (tag_a),
    .tag_di     (tag_di),
    .tag_web1   (tag_web1),
    .tag_web2   (tag_web2),
    .tag_do1    (tag_do1),
    .tag_do2    (tag_do2)
`ifdef DCACHE_TAG_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  // Tag SRAM: registered read, contents pre-loaded with tags that collide with the test tags
  logic [TAG_W-1:0] mem [2][32];
  logic             scramble = 1'b0;
  always @(posedge clk) begin
    if (scramble) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 32; s++)
          mem[w][s] <= TAG_W'(9 + 16 * $urandom_range(0, 3));
    end else begin
      if (tag_cs && tag_oe) begin
        tag_do1 <= mem[0][tag_a];
        tag_do2 <= mem[1][tag_a];
      end
      if (tag_cs && tag_web1) mem[0][tag_a] <= tag_di;
      if (tag_cs && tag_web2) mem[1][tag_a] <= tag_di;
    end
  end

  // Reference cache state: what each way of each set holds, and which way to evict next
  bit               mv [2][32];
  logic [TAG_W-1:0] mt [2][32];
  bit               ml [32];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               n_hits  = 0;
  int               n_miss  = 0;

  task automatic model_clear();
    for (int s = 0; s < 32; s++) begin
      mv[0][s] = 0; mv[1][s] = 0; ml[s] = 0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; fill_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    n_hits = 0; n_miss = 0;
  endtask

  // One full transaction; exp_hit/exp_way >= 0 pin the expected response to a fixed value
  task automatic do_req(input logic [31:0] addr, input int exp_hit, input int exp_way);
    int               idx;
    logic [TAG_W-1:0] tag;
    bit               h;
    bit               w;
    logic             eh;
    logic             ew;
    idx = int'((addr >> 4) % 32);
    tag = TAG_W'(addr >> 9);
    if (mv[0][idx] && mt[0][idx] == tag)      begin h = 1; w = 0; end
    else if (mv[1][idx] && mt[1][idx] == tag) begin h = 1; w = 1; end
    else begin
      h = 0;
      w = !mv[0][idx] ? 1'b0 : (!mv[1][idx] ? 1'b1 : ml[idx]);
    end
    eh = (exp_hit >= 0) ? exp_hit[0] : h;
    ew = (exp_way >= 0) ? exp_way[0] : w;

    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; #1;
    n_tests++;
    if (tag_cs !== 1'b1 || tag_oe !== 1'b1 || tag_a !== 5'(idx) || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept %h: cs=%b oe=%b a=%0d rv=%b rdy=%b, want 1 1 %0d 0 1", addr, tag_cs, tag_oe, tag_a, resp_valid, req_ready, idx);
    end

    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; fill_done = 1'($urandom_range(0, 1)); #1;
    n_tests++;
    if (resp_valid !== 1'b1 || resp_hit !== eh || resp_way !== ew) begin
      n_fail++;
      $display("FAIL resp %h: valid=%b hit=%b way=%b, want 1 %b %b", addr, resp_valid, resp_hit, resp_way, eh, ew);
    end

    if (h) begin
      ml[idx] = ~w; n_hits++;
      @(negedge clk);
      fill_done = 1'b0; #1;
      n_tests++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || tag_web1 !== 1'b0 || tag_web2 !== 1'b0) begin
        n_fail++;
        $display("FAIL after_hit %h: rdy=%b rv=%b web=%b%b, want 1 0 00", addr, req_ready, resp_valid, tag_web1, tag_web2);
      end
    end else begin
      n_miss++;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        fill_done = 1'b0; flush = 1'($urandom_range(0, 1)); req_valid = 1'($urandom_range(0, 1)); #1;
        n_tests++;
        if (req_ready !== 1'b0 || tag_cs !== 1'b0 || resp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL miss_wait %h: rdy=%b cs=%b rv=%b, want 0 0 0", addr, req_ready, tag_cs, resp_valid);
        end
      end
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0; fill_done = 1'b1; #1;
      n_tests++;
      if (req_ready !== 1'b0 || tag_web1 !== 1'b0 || tag_web2 !== 1'b0) begin
        n_fail++;
        $display("FAIL pre_fill %h: rdy=%b web=%b%b, want 0 00", addr, req_ready, tag_web1, tag_web2);
      end
      @(negedge clk);
      fill_done = 1'b0; #1;
      n_tests++;
      if (tag_cs !== 1'b1 || tag_oe !== 1'b0 || tag_a !== 5'(idx) || tag_di !== tag ||
          tag_web1 !== !w || tag_web2 !== w || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL fill %h: cs=%b oe=%b a=%0d di=%h web=%b%b rdy=%b, want 1 0 %0d %h %b%b 0",
                 addr, tag_cs, tag_oe, tag_a, tag_di, tag_web1, tag_web2, req_ready, idx, tag, !w, w);
      end
      @(negedge clk); #1;
      n_tests++;
      if (req_ready !== 1'b1 || tag_cs !== 1'b0) begin
        n_fail++;
        $display("FAIL post_fill %h: rdy=%b cs=%b, want 1 0", addr, req_ready, tag_cs);
      end
      mv[w][idx] = 1; mt[w][idx] = tag; ml[idx] = ~w;
    end
  endtask

  task automatic do_flush(input bit with_req);
    @(negedge clk);
    flush = 1'b1; req_valid = with_req; req_addr = $urandom; #1;
    n_tests++;
    if (tag_cs !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_cycle: cs=%b rdy=%b, want 0 1", tag_cs, req_ready);
    end
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0; #1;
    n_tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_after: rv=%b rdy=%b, want 0 1", resp_valid, req_ready);
    end
    model_clear();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_way !== 1'b0 ||
        tag_cs !== 1'b0 || tag_oe !== 1'b0 || tag_web1 !== 1'b0 || tag_web2 !== 1'b0 ||
        tag_a !== 5'd0 || tag_di !== '0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b rv=%b hit=%b way=%b cs=%b oe=%b web=%b%b a=%0d di=%h, want 1 0 0 0 0 0 00 0 0",
               req_ready, resp_valid, resp_hit, resp_way, tag_cs, tag_oe, tag_web1, tag_web2, tag_a, tag_di);
    end
  endtask

  task automatic test_cold_miss_fill_hit();
    do_req(32'h0000_1230, 0, 0);
    do_req(32'h0000_1230, 1, 0);
  endtask

  task automatic test_fill_both_ways();
    do_req(32'h0000_3230, 0, 1);
    do_req(32'h0000_3230, 1, 1);
  endtask

  task automatic test_lru_victim();
    do_req(32'h0000_5230, 0, 0);
    do_flush(1'b0);
    do_req(32'h0000_1230, 0, 0);
    do_req(32'h0000_3230, 0, 1);
    do_req(32'h0000_1230, 1, 0);
    do_req(32'h0000_5230, 0, 1);
  endtask

  task automatic test_flush();
    do_flush(1'b1);
    do_req(32'h0000_1230, 0, 0);
  endtask

  task automatic test_reset_mid_miss();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_F230;
    @(negedge clk);
    req_valid = 1'b0; #1;
    n_tests++;
    if (resp_valid !== 1'b1 || resp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_lookup: rv=%b hit=%b, want 1 0", resp_valid, resp_hit);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; fill_done = 1'b1;
    model_clear();
    @(negedge clk);
    fill_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (tag_web1 !== 1'b0 || tag_web2 !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_idle%0d: web=%b%b rdy=%b rv=%b, want 00 1 0", i, tag_web1, tag_web2, req_ready, resp_valid);
      end
      @(negedge clk);
    end
    do_req(32'h0000_1230, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_flush(1'($urandom_range(0, 1)));
      end else begin
        logic [31:0] a;
        int          s;
        s = ($urandom_range(0, 1) == 0) ? 3 : int'($urandom_range(0, 31));
        a = (32'(9 + 16 * $urandom_range(0, 3)) << 9) | (32'(s) << 4) | 32'($urandom_range(0, 15));
        do_req(a, -1, -1);
      end
    end
  endtask

`ifdef DCACHE_TAG_STATS_EN
  task automatic test_stats();
    apply_reset();
    #1;
    n_tests++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_reset: hit=%0d miss=%0d, want 0 0", hit_cnt, miss_cnt);
    end
    do_req(32'h0000_1230, 0, 0);
    do_req(32'h0000_1230, 1, 0);
    do_req(32'h0000_3230, 0, 1);
    do_req(32'h0000_3230, 1, 1);
    do_flush(1'b0);
    do_req(32'h0000_7230, 0, 0);
    do_req(32'h0000_7230, 1, 0);
    #1;
    n_tests++;
    if (hit_cnt !== 32'(n_hits) || miss_cnt !== 32'(n_miss)) begin
      n_fail++;
      $display("FAIL stats_count: hit=%0d miss=%0d, want %0d %0d", hit_cnt, miss_cnt, n_hits, n_miss);
    end
    apply_reset();
    #1;
    n_tests++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_clear: hit=%0d miss=%0d, want 0 0", hit_cnt, miss_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    scramble = 1'b1;
    @(negedge clk);
    scramble = 1'b0;
    test_reset();
    test_cold_miss_fill_hit();
    test_fill_both_ways();
    test_lru_victim();
    test_flush();
    test_reset_mid_miss();
    test_random();
`ifdef DCACHE_TAG_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
